// File: rtl/relu_maxpool_layer.sv
`default_nettype none
// ============================================================================
//  Module   : relu_maxpool_layer
//  Purpose  : ReLU followed by 2x2 stride-2 max pooling over K flattened
//             feature maps, one pooled element per clock under a
//             start/busy/done handshake. Works for fp16 and signed integers.
//  Revision : 1.0  initial release
// ============================================================================
module relu_maxpool_layer #(
  parameter int DATA_WIDTH = 16,
  parameter int FLOAT_MODE = 1,
  parameter int K          = 6,
  parameter int H          = 28,
  parameter int W          = 28
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     start,
  input  logic [K*H*W*DATA_WIDTH-1:0]              in_data,
  output logic [K*(H/2)*(W/2)*DATA_WIDTH-1:0]      res,
  output logic                                     busy,
  output logic                                     done
);

  localparam int HO  = H / 2;
  localparam int WO  = W / 2;
  localparam int NI  = K * H * W;
  localparam int NO  = K * HO * WO;
  localparam int IIW = (NI > 1) ? $clog2(NI) : 1;
  localparam int OIW = (NO > 1) ? $clog2(NO) : 1;
  localparam int KCW = (K  > 1) ? $clog2(K)  : 1;
  localparam int RCW = (HO > 1) ? $clog2(HO) : 1;
  localparam int CCW = (WO > 1) ? $clog2(WO) : 1;

  // fp16 mode only makes sense with 16-bit elements; maps need a full window
  if (FLOAT_MODE != 0 && DATA_WIDTH != 16) begin : g_fp_width_check
    $error("relu_maxpool_layer: FLOAT_MODE=1 requires DATA_WIDTH=16");
  end
  if (H < 2 || W < 2) begin : g_size_check
    $error("relu_maxpool_layer: H and W must be at least 2");
  end

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t                state_q, state_d;
  logic [KCW-1:0]        kc;
  logic [RCW-1:0]        rc;
  logic [CCW-1:0]        cc;
  logic                  last;
  logic [IIW-1:0]        idx00, idx01, idx10, idx11;
  logic [OIW-1:0]        out_idx;
  logic [DATA_WIDTH-1:0] in_elem [NI];
  logic [DATA_WIDTH-1:0] res_q   [NO];
  logic [DATA_WIDTH-1:0] v00, v01, v10, v11, m0, m1, pooled;

  // Negative values (sign bit set) clamp to zero; covers fp16 -0 and -NaN too
  function automatic logic [DATA_WIDTH-1:0] relu(input logic [DATA_WIDTH-1:0] v);
    return v[DATA_WIDTH-1] ? '0 : v;
  endfunction

  for (genvar i = 0; i < NI; i++) begin : g_unpack
    assign in_elem[i] = in_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  for (genvar i = 0; i < NO; i++) begin : g_pack
    assign res[i*DATA_WIDTH +: DATA_WIDTH] = res_q[i];
  end

  // Window addressing for the current output element (odd trailing row/col never reached)
  always_comb begin
    idx00   = IIW'(32'(kc) * (H * W) + 32'(rc) * (2 * W) + 32'(cc) * 2);
    idx01   = idx00 + IIW'(1);
    idx10   = idx00 + IIW'(W);
    idx11   = idx10 + IIW'(1);
    out_idx = OIW'(32'(kc) * (HO * WO) + 32'(rc) * WO + 32'(cc));
    last    = (32'(kc) == K - 1) && (32'(rc) == HO - 1) && (32'(cc) == WO - 1);
  end

  // ReLU then unsigned max; all operands are non-negative so raw bit order is value order
  always_comb begin
    v00    = relu(in_elem[idx00]);
    v01    = relu(in_elem[idx01]);
    v10    = relu(in_elem[idx10]);
    v11    = relu(in_elem[idx11]);
    m0     = (v00 > v01) ? v00 : v01;
    m1     = (v10 > v11) ? v10 : v11;
    pooled = (m0 > m1) ? m0 : m1;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and handshake outputs; start is ignored while running
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (last) state_d = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Counters and result store: cleared on accepted start, one element written per RUN edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kc <= '0;
      rc <= '0;
      cc <= '0;
      for (int i = 0; i < NO; i++) res_q[i] <= '0;
    end else if (state_q != S_RUN && start) begin
      kc <= '0;
      rc <= '0;
      cc <= '0;
      for (int i = 0; i < NO; i++) res_q[i] <= '0;
    end else if (state_q == S_RUN) begin
      res_q[out_idx] <= pooled;
      if (32'(cc) == WO - 1) begin
        cc <= '0;
        if (32'(rc) == HO - 1) begin
          rc <= '0;
          kc <= (32'(kc) == K - 1) ? '0 : kc + KCW'(1);
        end else begin
          rc <= rc + RCW'(1);
        end
      end else begin
        cc <= cc + CCW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_relu_maxpool_layer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_relu_maxpool_layer
//  Purpose  : Self-checking bench for relu_maxpool_layer using three
//             configurations (default 6x28x28, 2x4x4 integer, 1x5x5 odd).
//  Revision : 1.0  initial release
// ============================================================================
module tb_relu_maxpool_layer;

  localparam int N0 = 6 * 14 * 14;
  localparam int N1 = 2 * 2 * 2;
  localparam int N2 = 1 * 2 * 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic st0 = 1'b0, st1 = 1'b0, st2 = 1'b0;
  logic [6*28*28*16-1:0] in0 = '0;
  logic [2*4*4*16-1:0]   in1 = '0;
  logic [1*5*5*16-1:0]   in2 = '0;
  logic [N0*16-1:0]      res0;
  logic [N1*16-1:0]      res1;
  logic [N2*16-1:0]      res2;
  logic busy0, busy1, busy2, done0, done1, done2;

  int checks = 0;
  int errors = 0;

  logic [15:0] img  [0:6*28*28-1];
  logic [15:0] expv [0:N0-1];

  typedef struct {
    logic [15:0] a, b, c, d;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl [8];

  always #5 clk = ~clk;

  relu_maxpool_layer #(.DATA_WIDTH(16), .FLOAT_MODE(1), .K(6), .H(28), .W(28)) dut0 (
    .clk(clk), .rst(rst), .start(st0), .in_data(in0), .res(res0), .busy(busy0), .done(done0));
  relu_maxpool_layer #(.DATA_WIDTH(16), .FLOAT_MODE(0), .K(2), .H(4), .W(4)) dut1 (
    .clk(clk), .rst(rst), .start(st1), .in_data(in1), .res(res1), .busy(busy1), .done(done1));
  relu_maxpool_layer #(.DATA_WIDTH(16), .FLOAT_MODE(1), .K(1), .H(5), .W(5)) dut2 (
    .clk(clk), .rst(rst), .start(st2), .in_data(in2), .res(res2), .busy(busy2), .done(done2));

  // Reference: ReLU then max over each 2x2 window, straight from the definition
  task automatic model(input int k, input int h, input int w);
    int ho = h / 2;
    int wo = w / 2;
    logic [15:0] v, m;
    for (int kk = 0; kk < k; kk++)
      for (int r = 0; r < ho; r++)
        for (int c = 0; c < wo; c++) begin
          m = 16'h0000;
          for (int dr = 0; dr < 2; dr++)
            for (int dc = 0; dc < 2; dc++) begin
              v = img[kk*h*w + (2*r+dr)*w + 2*c + dc];
              if (v[15]) v = 16'h0000;
              if (v > m) m = v;
            end
          expv[kk*ho*wo + r*wo + c] = m;
        end
  endtask

  task automatic load(input int sel, input int n);
    for (int i = 0; i < n; i++)
      case (sel)
        0: in0[i*16 +: 16] = img[i];
        1: in1[i*16 +: 16] = img[i];
        default: in2[i*16 +: 16] = img[i];
      endcase
  endtask

  task automatic set_start(input int sel, input logic v);
    case (sel)
      0: st0 = v;
      1: st1 = v;
      default: st2 = v;
    endcase
  endtask

  function automatic logic get_busy(input int sel);
    return (sel == 0) ? busy0 : (sel == 1) ? busy1 : busy2;
  endfunction

  function automatic logic get_done(input int sel);
    return (sel == 0) ? done0 : (sel == 1) ? done1 : done2;
  endfunction

  function automatic logic [15:0] get_res(input int sel, input int i);
    return (sel == 0) ? res0[i*16 +: 16] : (sel == 1) ? res1[i*16 +: 16] : res2[i*16 +: 16];
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_res(input int sel, input int n, input string tag);
    logic [15:0] got;
    for (int i = 0; i < n; i++) begin
      got = get_res(sel, i);
      checks++;
      if (got !== expv[i]) begin
        errors++;
        $display("FAIL %s res[%0d]: got %h expected %h", tag, i, got, expv[i]);
      end
    end
  endtask

  // One pass: start pulse, count busy cycles and latency to done (bounded).
  // A non-negative repulse re-asserts start for one cycle mid-run.
  task automatic do_pass(input int sel, input int n, input int repulse, input string tag);
    int t, bc;
    @(negedge clk); set_start(sel, 1'b1);
    @(negedge clk); set_start(sel, 1'b0);
    check({tag, " busy after start"}, 32'(get_busy(sel)), 32'd1);
    t = 0; bc = 0;
    while (!get_done(sel) && t < n + 20) begin
      if (get_busy(sel)) bc++;
      set_start(sel, t == repulse);
      @(negedge clk);
      t++;
    end
    set_start(sel, 1'b0);
    check({tag, " done latency"}, 32'(t), 32'(n));
    check({tag, " busy cycles"}, 32'(bc), 32'(n));
    check({tag, " busy low at done"}, 32'(get_busy(sel)), 32'd0);
  endtask

  task automatic rand_img(input int n);
    for (int i = 0; i < n; i++) img[i] = 16'($urandom);
  endtask

  initial begin
    tbl[0] = '{16'hB800, 16'h3400, 16'h3800, 16'h3555, 16'h3800};
    tbl[1] = '{16'hFFFF, 16'h0005, 16'h0003, 16'h8000, 16'h0005};
    tbl[2] = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h0000};
    tbl[3] = '{16'h7E00, 16'h7BFF, 16'h0001, 16'h0000, 16'h7E00};
    tbl[4] = '{16'hFE00, 16'h0010, 16'hFFFF, 16'h000F, 16'h0010};
    tbl[5] = '{16'h7FFF, 16'h7FFE, 16'h0000, 16'h8001, 16'h7FFF};
    tbl[6] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    tbl[7] = '{16'h0001, 16'h0002, 16'h0004, 16'h0003, 16'h0004};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset busy0", 32'(busy0), 0);
    check("reset done0", 32'(done0), 0);
    check("reset res0 zero", 32'(res0 == '0), 1);
    rst = 1'b0;
    @(negedge clk);
    check("idle busy1", 32'(busy1), 0);
    check("idle done2", 32'(done2), 0);

    // Default config, every element 1.0 in fp16
    for (int i = 0; i < 6*28*28; i++) img[i] = 16'h3C00;
    for (int i = 0; i < N0; i++) expv[i] = 16'h3C00;
    load(0, 6*28*28);
    do_pass(0, N0, -1, "ones");
    check("ones done high", 32'(done0), 1);
    check_res(0, N0, "ones");

    // Random data with a start re-pulse mid-run (must not restart)
    rand_img(6*28*28); model(6, 28, 28); load(0, 6*28*28);
    do_pass(0, N0, 9, "repulse");
    check_res(0, N0, "repulse");

    // Asynchronous reset in the middle of a pass
    @(negedge clk); st0 = 1'b1;
    @(negedge clk); st0 = 1'b0;
    repeat (499) @(negedge clk);
    check("pre-reset busy", 32'(busy0), 1);
    #2 rst = 1'b1;
    #1;
    check("mid reset busy", 32'(busy0), 0);
    check("mid reset done", 32'(done0), 0);
    check("mid reset res zero", 32'(res0 == '0), 1);
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    check("post reset idle", 32'(busy0), 0);
    rand_img(6*28*28); model(6, 28, 28); load(0, 6*28*28);
    do_pass(0, N0, -1, "after reset");
    check_res(0, N0, "after reset");

    // Table of single windows at channel 0, (0,0); everything else negative
    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < 32; i++) img[i] = 16'hBC00;
      img[0] = tbl[v].a; img[1] = tbl[v].b; img[4] = tbl[v].c; img[5] = tbl[v].d;
      for (int i = 0; i < N1; i++) expv[i] = 16'h0000;
      expv[0] = tbl[v].exp;
      load(1, 32);
      do_pass(1, N1, -1, $sformatf("tbl%0d", v));
      check_res(1, N1, $sformatf("tbl%0d", v));
    end

    // Integer mode: channel 1 window (0,1) holds the distinct values
    for (int i = 0; i < 32; i++) img[i] = 16'h0001;
    img[18] = 16'hFFFF; img[19] = 16'h0005; img[22] = 16'h0003; img[23] = 16'h8000;
    for (int i = 0; i < N1; i++) expv[i] = 16'h0001;
    expv[5] = 16'h0005;
    load(1, 32);
    do_pass(1, N1, -1, "int order");
    check_res(1, N1, "int order");

    // Random small config passes
    for (int p = 0; p < 6; p++) begin
      rand_img(32); model(2, 4, 4); load(1, 32);
      do_pass(1, N1, -1, "rand1");
      check_res(1, N1, "rand1");
    end

    // Odd size: last row and column must be ignored
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        img[r*5+c] = (r == 4 || c == 4) ? 16'h7BFF : 16'h3000;
    for (int i = 0; i < N2; i++) expv[i] = 16'h3000;
    load(2, 25);
    do_pass(2, N2, -1, "odd");
    check_res(2, N2, "odd");
    for (int p = 0; p < 6; p++) begin
      rand_img(25); model(1, 5, 5); load(2, 25);
      do_pass(2, N2, -1, "rand2");
      check_res(2, N2, "rand2");
    end

    // start held high through DONE restarts immediately with cleared results
    begin
      int t;
      rand_img(32); model(2, 4, 4); load(1, 32);
      @(negedge clk); st1 = 1'b1;
      @(negedge clk);
      t = 0;
      while (!done1 && t < N1 + 20) begin @(negedge clk); t++; end
      check("held first latency", 32'(t), 32'(N1));
      check_res(1, N1, "held first");
      @(negedge clk);
      check("held restart done", 32'(done1), 0);
      check("held restart busy", 32'(busy1), 1);
      check("held restart res zero", 32'(res1 == '0), 1);
      st1 = 1'b0;
      t = 0;
      while (!done1 && t < N1 + 20) begin @(negedge clk); t++; end
      check("held second latency", 32'(t), 32'(N1));
      check_res(1, N1, "held second");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
